// File: rtl/mc_main_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: decodes IR opcode and sequences one micro-step per clock.
// Latency: 3-5 cycles per instruction (beq/bne/j 3, R/sw/addi 4, lw 5) plus one cycle per mem_ready=0 wait cycle.
// Backpressure: stalls in FETCH, MEMREAD and MEMWRITE until mem_ready; memwrite is held while waiting.
//
// Ports:
//   clk, reset      rising-edge clock, asynchronous active-low reset
//   op, zero        IR[31:26] and ALU zero flag
//   mem_ready       memory access completes this cycle
//   iord..pcsrc     datapath mux selects and write enables (Moore, from state)
//   pcen, retire    PC load enable and retire pulse (also depend on zero / mem_ready)
//   illegal         pulse in DECODE for an unsupported opcode
//   instret         retired-instruction counter, wraps at 2^32
module mc_main_ctrl #(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        memwrite,
  output logic        irwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        regwrite,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [1:0]  pcsrc,
  output logic        pcen,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  state_t     state;
  logic [5:0] op_q;       // opcode captured in DECODE; later states use this, not the live op
  logic       first_cyc;  // high for the first active cycle after reset release
  logic       hold;

  // With RESET_PC_WRITE=0 the first post-reset FETCH makes no PC/IR write and is repeated.
  assign hold = first_cyc & ~RESET_PC_WRITE;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      op_q      <= '0;
      first_cyc <= 1'b1;
      instret   <= '0;
    end else begin
      first_cyc <= 1'b0;
      if (retire)
        instret <= instret + 32'd1;
      case (state)
        S_FETCH:    if (mem_ready && !hold) state <= S_DECODE;
        S_DECODE: begin
          op_q <= op;
          case (op)
            OP_LW, OP_SW:   state <= S_MEMADR;
            OP_RTYPE:       state <= S_EXECUTE;
            OP_BEQ, OP_BNE: state <= S_BRANCH;
            OP_ADDI:        state <= S_ADDIEX;
            OP_J:           state <= S_JUMP;
            default:        state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= (op_q == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECUTE:  state <= S_ALUWB;
        S_ADDIEX:   state <= S_ADDIWB;
        default:    state <= S_FETCH;  // MEMWB, ALUWB, ADDIWB, BRANCH, JUMP
      endcase
    end
  end

  always_comb begin
    iord     = 1'b0;
    memwrite = 1'b0;
    irwrite  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcen     = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready & ~hold;
        pcen    = mem_ready & ~hold;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        illegal = !(op == OP_RTYPE || op == OP_LW || op == OP_SW || op == OP_BEQ ||
                    op == OP_BNE || op == OP_ADDI || op == OP_J);
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_MEMREAD: iord = 1'b1;
      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_MEMWRITE: begin
        iord     = 1'b1;
        memwrite = 1'b1;
        retire   = mem_ready;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = 2'b10;
      end
      S_ALUWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_BRANCH: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        pcen    = (op_q == OP_BEQ) ? zero : ~zero;
        retire  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      S_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      S_JUMP: begin
        pcsrc  = 2'b10;
        pcen   = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
    // Enables must drop the instant reset asserts, not at the next edge.
    if (!reset) begin
      memwrite = 1'b0;
      irwrite  = 1'b0;
      regwrite = 1'b0;
      pcen     = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
module tb_mc_main_ctrl;

  localparam bit RPW = 1'b0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]  alusrcb, aluop, pcsrc;
  logic        pcen, retire, illegal;
  logic [31:0] instret;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_instret = 32'd0;

  mc_main_ctrl #(.RESET_PC_WRITE(RPW)) dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .retire(retire), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  // Output bundle: {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,aluop,pcsrc,pcen,retire,illegal}
  logic [15:0] outs;
  assign outs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, aluop, pcsrc, pcen, retire, illegal};

  function automatic logic [15:0] mk(input logic io, mw, irw, rd, m2r, rw, sa,
                                     input logic [1:0] sb, ao, ps,
                                     input logic pe, rt, il);
    return {io, mw, irw, rd, m2r, rw, sa, sb, ao, ps, pe, rt, il};
  endfunction

  function automatic logic supported(input logic [5:0] o);
    logic [5:0] legal [7] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    foreach (legal[i]) if (legal[i] == o) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
  task automatic step(input logic [15:0] exp, input logic mr, input logic z,
                      input logic [5:0] opv, input string tag);
    mem_ready = mr;
    zero      = z;
    op        = opv;
    @(negedge clk);
    chk({tag, " outputs"}, {16'h0, outs}, {16'h0, exp});
    chk({tag, " instret"}, instret, exp_instret);
    @(posedge clk);
    #1;
    if (exp[1]) exp_instret = exp_instret + 32'd1;
  endtask

  // Cycle where op and zero must not matter; mem_ready is given.
  task automatic step_r(input logic [15:0] exp, input logic mr, input string tag);
    logic       zz;
    logic [5:0] oo;
    zz = 1'($urandom_range(1, 0));
    oo = 6'($urandom_range(63, 0));
    step(exp, mr, zz, oo, tag);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(1, 0));
  endfunction

  // Expected cycle-by-cycle behaviour of a single instruction.
  task automatic run_instr(input logic [5:0] o, input int fs, input int ms,
                           input logic z, input logic abort_wb);
    for (int i = 0; i < fs; i++)
      step_r(mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b0, "fetch_wait");
    step_r(mk(0,0,1,0,0,0,0,2'b01,2'b00,2'b00,1,0,0), 1'b1, "fetch");
    step(mk(0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0,!supported(o)), rnd_bit(), rnd_bit(), o, "decode");
    if (!supported(o)) return;
    case (o)
      OP_R: begin
        step_r(mk(0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0,0), rnd_bit(), "execute");
        step_r(mk(0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,1,0), rnd_bit(), "aluwb");
      end
      OP_LW: begin
        step_r(mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rnd_bit(), "lw_memadr");
        for (int i = 0; i < ms; i++)
          step_r(mk(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0, "memread_wait");
        step_r(mk(1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b1, "memread");
        if (!abort_wb) begin
          step_r(mk(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,1,0), rnd_bit(), "memwb");
        end else begin
          mem_ready = 1'b1;
          @(negedge clk);
          chk("memwb_pre_abort", {16'h0, outs}, {16'h0, mk(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,1,0)});
          #1 reset = 1'b0;
          #1;
          chk("abort_outputs", {16'h0, outs}, {16'h0, mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0)});
          chk("abort_regwrite", {31'h0, regwrite}, 32'd0);
          chk("abort_instret", instret, 32'd0);
          exp_instret = 32'd0;
          @(posedge clk);
          #1 reset = 1'b1;
          if (!RPW)
            step_r(mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b1, "post_abort_hold");
        end
      end
      OP_SW: begin
        step_r(mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rnd_bit(), "sw_memadr");
        for (int i = 0; i < ms; i++)
          step_r(mk(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0,0), 1'b0, "memwrite_wait");
        step_r(mk(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,1,0), 1'b1, "memwrite");
      end
      OP_BEQ, OP_BNE: begin
        logic [5:0] oo;
        oo = 6'($urandom_range(63, 0));
        step(mk(0,0,0,0,0,0,1,2'b00,2'b01,2'b01,(o == OP_BEQ) ? z : !z,1,0),
             rnd_bit(), z, oo, (o == OP_BEQ) ? "beq" : "bne");
      end
      OP_ADDI: begin
        step_r(mk(0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0,0), rnd_bit(), "addiex");
        step_r(mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,1,0), rnd_bit(), "addiwb");
      end
      OP_J: step_r(mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,1,0), rnd_bit(), "jump");
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] pool [9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_BAD, 6'b001111};
    reset     = 1'b0;
    op        = '0;
    zero      = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {16'h0, outs}, {16'h0, mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0)});
    chk("reset_instret", instret, 32'd0);
    reset = 1'b1;
    if (!RPW)
      step_r(mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0,0), 1'b1, "release_hold");

    run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
    run_instr(OP_ADDI, 0, 0, 1'b0, 1'b0);
    chk("instret_after_two_addi", instret, 32'd2);
    run_instr(OP_BEQ, 0, 0, 1'b0, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1, 1'b0);
    run_instr(OP_BNE, 0, 0, 1'b0, 1'b0);
    run_instr(OP_BNE, 0, 0, 1'b1, 1'b0);
    run_instr(OP_J,   0, 0, 1'b0, 1'b0);
    run_instr(OP_LW,  0, 2, 1'b0, 1'b0);
    run_instr(OP_SW,  0, 1, 1'b0, 1'b0);
    run_instr(OP_BAD, 0, 0, 1'b0, 1'b0);
    run_instr(OP_R,   1, 0, 1'b0, 1'b0);
    run_instr(OP_LW,  0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 80; n++) begin
      run_instr(pool[$urandom_range(8, 0)], int'($urandom_range(2, 0)),
                int'($urandom_range(2, 0)), rnd_bit(), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
